// File: rtl/sys_timer_pkg.sv
// Shared definitions for the system timer peripheral: bus write-size codes,
// register offsets, CTRL bit positions and the default window base.
package sys_timer_pkg;

  localparam int RAM_W_OP_WIDTH = 2;

  typedef enum logic [RAM_W_OP_WIDTH-1:0] {
    RAM_W_OP_BYTE = 2'd0,
    RAM_W_OP_HALF = 2'd1,
    RAM_W_OP_WORD = 2'd2
  } ram_w_op_e;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h1000_0000;

  localparam logic [4:0] TIMER_CTRL_OFS     = 5'h00;
  localparam logic [4:0] TIMER_PRESCALE_OFS = 5'h04;
  localparam logic [4:0] TIMER_COUNT_OFS    = 5'h08;
  localparam logic [4:0] TIMER_COMPARE_OFS  = 5'h0C;
  localparam logic [4:0] TIMER_STATUS_OFS   = 5'h10;

  localparam int TIMER_EN_BIT   = 0;
  localparam int TIMER_AUTO_BIT = 1;
  localparam int TIMER_IE_BIT   = 2;

  // CTRL register image; field order matches the bit indices above.
  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } timer_ctrl_t;

endpackage

// File: rtl/sys_timer_bus_wmerge.sv
// Byte-lane write merge: folds a lane-aligned bus write of byte, half or
// word size into an existing 32-bit register value.
module bus_wmerge
  import sys_timer_pkg::*;
(
  input  logic [31:0]               old_data,
  input  logic [31:0]               wdata,
  input  logic [1:0]                adr_lo,
  input  logic [RAM_W_OP_WIDTH-1:0] w_op,
  output logic [31:0]               merged
);

  // Replace only the lanes addressed by the write size and low address bits.
  always_comb begin
    merged = old_data;
    case (w_op)
      RAM_W_OP_BYTE: begin
        case (adr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[15:8];
          2'd2:    merged[23:16] = wdata[23:16];
          default: merged[31:24] = wdata[31:24];
        endcase
      end
      RAM_W_OP_HALF: begin
        if (adr_lo[1]) merged[31:16] = wdata[31:16];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped timer: prescaled up-counter with compare match, one-shot or
// auto-reload mode, sticky W1C pending flag and a level interrupt request.
module sys_timer
  import sys_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = TIMER_BASE_ADDR,
  parameter int          PRESC_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sys_bus_request,
  input  logic                      sys_bus_we,
  input  logic [31:0]               sys_bus_adr,
  input  logic [31:0]               sys_bus_wdata,
  input  logic [RAM_W_OP_WIDTH-1:0] dram_w_op,
  output logic [31:0]               sys_bus_rdata,
  output logic                      int_flag_o
);

  logic                   win_hit;
  logic                   wr_en;
  logic                   rd_en;
  logic [2:0]             reg_idx;
  logic                   wr_ctrl;
  logic                   wr_presc;
  logic                   wr_count;
  logic                   wr_compare;
  logic                   wr_status;
  timer_ctrl_t            ctrl;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [PRESC_WIDTH-1:0] pre_cnt;
  logic [31:0]            count;
  logic [31:0]            compare;
  logic                   pend;
  logic                   int_flag;
  logic                   tick;
  logic                   match;
  logic [31:0]            reg_val;
  logic [31:0]            merge_old;
  logic [31:0]            merged;

  assign win_hit    = (sys_bus_adr & ~32'h1F) == BASE_ADDR;
  assign reg_idx    = sys_bus_adr[4:2];
  assign wr_en      = sys_bus_request & sys_bus_we & win_hit;
  assign rd_en      = sys_bus_request & ~sys_bus_we & win_hit;
  assign wr_ctrl    = wr_en && (reg_idx == TIMER_CTRL_OFS[4:2]);
  assign wr_presc   = wr_en && (reg_idx == TIMER_PRESCALE_OFS[4:2]);
  assign wr_count   = wr_en && (reg_idx == TIMER_COUNT_OFS[4:2]);
  assign wr_compare = wr_en && (reg_idx == TIMER_COMPARE_OFS[4:2]);
  assign wr_status  = wr_en && (reg_idx == TIMER_STATUS_OFS[4:2]);

  // Current contents of the addressed register; unmapped slots read zero.
  always_comb begin
    reg_val = '0;
    case (reg_idx)
      TIMER_CTRL_OFS[4:2]:     reg_val[2:0] = ctrl;
      TIMER_PRESCALE_OFS[4:2]: reg_val[PRESC_WIDTH-1:0] = prescale;
      TIMER_COUNT_OFS[4:2]:    reg_val = count;
      TIMER_COMPARE_OFS[4:2]:  reg_val = compare;
      TIMER_STATUS_OFS[4:2]:   reg_val[0] = pend;
      default:                 reg_val = '0;
    endcase
  end

  // STATUS is write-1-to-clear, so merge against zero: lanes not written
  // must never echo the live PEND bit back as a clear request.
  assign merge_old = (reg_idx == TIMER_STATUS_OFS[4:2]) ? 32'h0 : reg_val;

  bus_wmerge u_wmerge (
    .old_data (merge_old),
    .wdata    (sys_bus_wdata),
    .adr_lo   (sys_bus_adr[1:0]),
    .w_op     (dram_w_op),
    .merged   (merged)
  );

  assign sys_bus_rdata = rd_en ? reg_val : 32'h0;
  assign tick          = ctrl.en && (pre_cnt == prescale);
  assign match         = tick && (count == compare);

  // Prescaler: runs only while enabled, restarts on wrap or PRESCALE write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          pre_cnt <= '0;
    else if (wr_presc || !ctrl.en || tick) pre_cnt <= '0;
    else                                 pre_cnt <= pre_cnt + PRESC_WIDTH'(1);
  end

  // CTRL: a software write overrides the one-shot self-disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.en      <= merged[TIMER_EN_BIT];
      ctrl.auto_rl <= merged[TIMER_AUTO_BIT];
      ctrl.ie      <= merged[TIMER_IE_BIT];
    end else if (match && !ctrl.auto_rl) begin
      ctrl.en <= 1'b0;
    end
  end

  // PEND: a match in the same cycle beats a software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pend <= 1'b0;
    else if (match)                    pend <= 1'b1;
    else if (wr_status && merged[0])   pend <= 1'b0;
  end

  // Plain software-owned configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      compare  <= 32'hFFFF_FFFF;
    end else begin
      if (wr_presc)   prescale <= merged[PRESC_WIDTH-1:0];
      if (wr_compare) compare  <= merged;
    end
  end

  // COUNT: software write wins over a tick; auto-reload restarts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= 32'h0;
    else if (wr_count)            count <= merged;
    else if (tick) begin
      if (match && ctrl.auto_rl)  count <= 32'h0;
      else                        count <= count + 32'd1;
    end
  end

  // Interrupt request follows PEND & IE one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_flag <= 1'b0;
    else        int_flag <= pend & ctrl.ie;
  end

  assign int_flag_o = int_flag;

endmodule

// File: tb/tb_sys_timer.sv
// Self-checking bench for sys_timer: directed scenarios plus random bus
// traffic, all checked against a behavioural model through a read scoreboard.
module tb_sys_timer;
  import sys_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRESC = BASE + 32'h04;
  localparam logic [31:0] A_COUNT = BASE + 32'h08;
  localparam logic [31:0] A_COMP = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      sys_bus_request;
  logic                      sys_bus_we;
  logic [31:0]               sys_bus_adr;
  logic [31:0]               sys_bus_wdata;
  logic [RAM_W_OP_WIDTH-1:0] dram_w_op;
  logic [31:0]               sys_bus_rdata;
  logic                      int_flag_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  // Behavioural model state
  logic        m_en, m_auto, m_ie, m_pend, m_int;
  logic [15:0] m_presc;
  logic [31:0] m_count, m_compare;
  int          m_phase;

  always #5 clk = ~clk;

  sys_timer #(.BASE_ADDR(BASE), .PRESC_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sys_bus_request (sys_bus_request),
    .sys_bus_we      (sys_bus_we),
    .sys_bus_adr     (sys_bus_adr),
    .sys_bus_wdata   (sys_bus_wdata),
    .dram_w_op       (dram_w_op),
    .sys_bus_rdata   (sys_bus_rdata),
    .int_flag_o      (int_flag_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] laneMask(input logic [1:0] op, input logic [1:0] a);
    if (op == 2'd0) return 32'h0000_00FF << (8 * a);
    if (op == 2'd1) return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if ((a & ~32'h1F) != BASE) return 32'h0;
    case (a[4:2])
      3'd0:    return {29'b0, m_ie, m_auto, m_en};
      3'd1:    return {16'b0, m_presc};
      3'd2:    return m_count;
      3'd3:    return m_compare;
      3'd4:    return {31'b0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: ticks every (PRESCALE+1) cycles of enabled time since
  // the last restart; writes merge through a byte-enable mask.
  logic        md_tick, md_match, n_en, n_auto, n_ie, n_pend;
  logic [15:0] n_presc;
  logic [31:0] n_count, n_compare, md_mask, md_wv;
  int          n_phase;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_int = 0;
      m_presc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_phase = 0;
    end else begin
      md_tick  = m_en && ((m_phase % (int'(m_presc) + 1)) == int'(m_presc));
      md_match = md_tick && (m_count == m_compare);
      n_phase = m_en ? m_phase + 1 : 0;
      n_count = m_count;
      if (md_tick) n_count = (md_match && m_auto) ? 32'h0 : m_count + 32'd1;
      n_en = (md_match && !m_auto) ? 1'b0 : m_en;
      n_auto = m_auto; n_ie = m_ie; n_pend = m_pend;
      n_presc = m_presc; n_compare = m_compare;
      if (sys_bus_request && sys_bus_we && ((sys_bus_adr & ~32'h1F) == BASE)) begin
        md_mask = laneMask(dram_w_op, sys_bus_adr[1:0]);
        case (sys_bus_adr[4:2])
          3'd0: begin
            md_wv = ({29'b0, m_ie, m_auto, m_en} & ~md_mask) | (sys_bus_wdata & md_mask);
            n_en = md_wv[0]; n_auto = md_wv[1]; n_ie = md_wv[2];
          end
          3'd1: begin
            md_wv = ({16'b0, m_presc} & ~md_mask) | (sys_bus_wdata & md_mask);
            n_presc = md_wv[15:0];
            n_phase = 0;
          end
          3'd2: n_count = (m_count & ~md_mask) | (sys_bus_wdata & md_mask);
          3'd3: n_compare = (m_compare & ~md_mask) | (sys_bus_wdata & md_mask);
          3'd4: begin
            md_wv = sys_bus_wdata & md_mask;
            if (md_wv[0]) n_pend = 1'b0;
          end
          default: ;
        endcase
      end
      if (md_match) n_pend = 1'b1;
      m_int = m_pend & m_ie;
      m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_pend = n_pend;
      m_presc = n_presc; m_count = n_count; m_compare = n_compare; m_phase = n_phase;
    end
  end

  // Monitor: interrupt every cycle, read data whenever a read is on the bus.
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    checkOutput("int_flag_o", {31'b0, int_flag_o}, {31'b0, m_int});
    if (sys_bus_request && !sys_bus_we) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL scoreboard: read seen with no expected entry, got 0x%08h, expected queued value", sys_bus_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rdata", sys_bus_rdata, mon_exp);
      end
    end
  end

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] adr,
                               input logic [31:0] wdata, input logic [1:0] op);
    @(posedge clk);
    #1;
    sys_bus_request = req;
    sys_bus_we      = we;
    sys_bus_adr     = adr;
    sys_bus_wdata   = wdata;
    dram_w_op       = op;
    if (req && !we) exp_q.push_back(modelRead(adr));
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, adr, data, RAM_W_OP_WORD);
  endtask

  task automatic rd(input logic [31:0] adr);
    applyStimulus(1'b1, 1'b0, adr, 32'h0, RAM_W_OP_WORD);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, RAM_W_OP_WORD);
  endtask

  task automatic readConst(input logic [31:0] adr, input logic [31:0] exp, input string name);
    rd(adr);
    #1;
    checkOutput(name, sys_bus_rdata, exp);
  endtask

  int          kind, idx, op, shift;
  logic [1:0]  lo;
  logic [31:0] v, a, mask, wd;

  initial begin
    sys_bus_request = 0; sys_bus_we = 0; sys_bus_adr = 0;
    sys_bus_wdata = 0; dram_w_op = RAM_W_OP_WORD;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    $display("[TB] test 1: reset values");
    for (int i = 0; i < 8; i++)
      readConst(BASE + 32'(4 * i), (i == 3) ? 32'hFFFF_FFFF : 32'h0, "reset read");

    $display("[TB] test 2: auto-reload, compare 5");
    wr(A_PRESC, 0); wr(A_COMP, 5); wr(A_CTRL, 7);
    for (int k = 1; k <= 14; k++) readConst(A_COUNT, 32'((k - 1) % 6), "auto count seq");
    readConst(A_STAT, 32'h1, "auto pend set");
    wr(A_CTRL, 6); wr(A_STAT, 1); idle(2);
    readConst(A_STAT, 32'h0, "pend cleared");

    $display("[TB] test 3: one-shot with prescale 3");
    wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_COUNT, 0); wr(A_PRESC, 3); wr(A_COMP, 2); wr(A_CTRL, 5);
    for (int k = 1; k <= 20; k++)
      readConst(A_COUNT, ((k - 1) / 4 > 3) ? 32'd3 : 32'((k - 1) / 4), "oneshot count");
    readConst(A_CTRL, 32'h4, "oneshot en cleared");
    readConst(A_STAT, 32'h1, "oneshot pend");

    $display("[TB] test 4: lane merge into COMPARE");
    wr(A_CTRL, 0); wr(A_STAT, 1); wr(A_COMP, 32'hFFFF_FFFF);
    applyStimulus(1, 1, BASE + 32'h0E, 32'h00AB_0000, RAM_W_OP_BYTE);
    applyStimulus(1, 1, BASE + 32'h0C, 32'h0000_1234, RAM_W_OP_HALF);
    readConst(A_COMP, 32'hFFAB_1234, "lane merge");

    $display("[TB] test 5: wrap without flag, then match at 7");
    wr(A_PRESC, 0); wr(A_COMP, 7); wr(A_COUNT, 32'hFFFF_FFFF); wr(A_CTRL, 1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)      readConst(A_COUNT, 32'hFFFF_FFFF, "pre-wrap count");
      else if (k == 2) readConst(A_STAT, 32'h0, "no pend on wrap");
      else             readConst(A_COUNT, (k - 2 > 8) ? 32'd8 : 32'(k - 2), "post-wrap count");
    end
    readConst(A_STAT, 32'h1, "pend at 7");

    $display("[TB] test 6: match and clear together, out-of-window access");
    wr(A_STAT, 1); wr(A_COUNT, 0); wr(A_COMP, 3); wr(A_CTRL, 1);
    idle(3);
    wr(A_STAT, 1);
    readConst(A_STAT, 32'h1, "set beats clear");
    readConst(BASE + 32'h20, 32'h0, "outside read");
    wr(BASE + 32'h28, 32'h55); wr(BASE + 32'h20, 32'h7);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    readConst(BASE + 32'h14, 32'h0, "unmapped read");
    readConst(A_COUNT, 32'd4, "count untouched");
    readConst(A_CTRL, 32'h0, "ctrl untouched");

    $display("[TB] test 7: async reset drops interrupt");
    wr(A_CTRL, 4); idle(2);
    @(posedge clk); #3;
    checkOutput("int before reset", {31'b0, int_flag_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("int async drop", {31'b0, int_flag_o}, 32'h0);
    #3 rst_n = 1'b1;
    readConst(A_COMP, 32'hFFFF_FFFF, "compare after reset");
    readConst(A_STAT, 32'h0, "status after reset");

    $display("[TB] test 8: random traffic");
    for (int n = 0; n < 1500; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        a = BASE + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) a = a + 32'h20;
        rd(a);
      end else if (kind <= 7) begin
        idx = $urandom_range(0, 5);
        op  = $urandom_range(0, 2);
        lo  = (op == 0) ? 2'($urandom_range(0, 3)) : (op == 1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
        if ((idx == 0 || idx == 4) && $urandom_range(0, 3) != 0) lo = 2'b00;
        case (idx)
          0:       v = 32'($urandom_range(0, 7));
          1:       v = 32'($urandom_range(0, 3));
          2, 3:    v = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 12));
          4:       v = 32'($urandom_range(0, 1));
          default: v = $urandom();
        endcase
        shift = (op == 0) ? 8 * lo : (op == 1) ? 16 * lo[1] : 0;
        mask = laneMask(2'(op), lo);
        wd = ($urandom() & ~mask) | ((v << shift) & mask);
        a = BASE + 32'(4 * ((idx == 5) ? $urandom_range(5, 7) : idx)) + 32'(lo);
        if ($urandom_range(0, 15) == 0) a = a ^ 32'h0000_0040;
        applyStimulus(1, 1, a, wd, 2'(op));
      end else begin
        idle(1);
      end
    end
    idle(2);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
